// File: rtl/two_ops_acc_pkg.sv
// Shared constants and types for the two-op subtract stage and its block accumulator.
package two_ops_pkg;
    localparam int DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // A 1-word block still needs one counter bit.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction
endpackage

// File: rtl/two_ops_acc.sv
// Sums COUNT consecutive two-op results and emits each block sum on a held valid/ready port.
// Optional carry-out flag on port OVF when TWO_OPS_ACC_OVF_EN is defined.
module two_ops_acc
    import two_ops_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 10
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] I,
    input  logic              I_VALID,
    output logic              I_READY,
    input  logic              CLR,
    output logic [ACC_W-1:0]  O,
    output logic              O_VALID,
`ifdef TWO_OPS_ACC_OVF_EN
    output logic              OVF,
`endif
    input  logic              O_READY
);
    localparam int CW = cnt_width(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
`ifdef TWO_OPS_ACC_OVF_EN
    localparam int SW = ACC_W + 1;
`else
    localparam int SW = ACC_W;
`endif

    state_t         state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  sum;
    logic           accept;
    logic           last;

    // Ready never looks at I_VALID, so no combinational loop through the upstream handshake.
    assign I_READY = RESETN && (state == ACCUM) && !CLR;
    assign accept  = I_VALID && I_READY;
    assign last    = (cnt == LAST);
    assign sum     = SW'(acc) + SW'(I);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            O       <= '0;
            O_VALID <= 1'b0;
        end else if (state == ACCUM) begin
            if (CLR) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (last) begin
                    O       <= sum[ACC_W-1:0];
                    O_VALID <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                    state   <= EMIT;
                end else begin
                    acc <= sum[ACC_W-1:0];
                    cnt <= cnt + 1'b1;
                end
            end
        end else if (O_READY) begin
            O_VALID <= 1'b0;
            state   <= ACCUM;
        end
    end

`ifdef TWO_OPS_ACC_OVF_EN
    logic flag;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            flag <= 1'b0;
            OVF  <= 1'b0;
        end else if (state == ACCUM) begin
            if (CLR) begin
                flag <= 1'b0;
            end else if (accept) begin
                if (last) begin
                    OVF  <= flag | sum[ACC_W];
                    flag <= 1'b0;
                end else begin
                    flag <= flag | sum[ACC_W];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_two_ops_acc.sv
// Bench for two_ops_acc: three configurations driven in parallel against a block-sum reference model.
module tb_two_ops_acc;
    localparam int ND = 3;

    logic       CLK = 1'b0;
    logic       RESETN, I_VALID, CLR, O_READY;
    logic [7:0] I;
    logic [ND-1:0] rdy, vld, ovf;
    logic [9:0] o0, o2;
    logic [8:0] o1;

    always #5 CLK = ~CLK;

    two_ops_acc #(.COUNT(4), .ACC_W(10)) u_acc (
        .CLK(CLK), .RESETN(RESETN), .I(I), .I_VALID(I_VALID), .I_READY(rdy[0]), .CLR(CLR),
        .O(o0), .O_VALID(vld[0]),
`ifdef TWO_OPS_ACC_OVF_EN
        .OVF(ovf[0]),
`endif
        .O_READY(O_READY));

    two_ops_acc #(.COUNT(4), .ACC_W(9)) u_acc9 (
        .CLK(CLK), .RESETN(RESETN), .I(I), .I_VALID(I_VALID), .I_READY(rdy[1]), .CLR(CLR),
        .O(o1), .O_VALID(vld[1]),
`ifdef TWO_OPS_ACC_OVF_EN
        .OVF(ovf[1]),
`endif
        .O_READY(O_READY));

    two_ops_acc #(.COUNT(1), .ACC_W(10)) u_acc1 (
        .CLK(CLK), .RESETN(RESETN), .I(I), .I_VALID(I_VALID), .I_READY(rdy[2]), .CLR(CLR),
        .O(o2), .O_VALID(vld[2]),
`ifdef TWO_OPS_ACC_OVF_EN
        .OVF(ovf[2]),
`endif
        .O_READY(O_READY));

`ifndef TWO_OPS_ACC_OVF_EN
    assign ovf = '0;
`endif

    // reference model: block sums as plain integers
    bit m_emit [ND];
    int m_o    [ND];
    int m_sum  [ND];
    int m_k    [ND];
    bit m_flag [ND];
    bit m_ovf  [ND];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int cnt_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int aw_of(input int d);
        return (d == 1) ? 9 : 10;
    endfunction

    function automatic logic [31:0] o_of(input int d);
        case (d)
            0:       return 32'(o0);
            1:       return 32'(o1);
            default: return 32'(o2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] i, input bit c, input bit rd);
        RESETN  = r;
        I_VALID = v;
        I       = i;
        CLR     = c;
        O_READY = rd;
    endtask

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            int lim, s;
            lim = 1 << aw_of(d);
            if (!RESETN) begin
                m_emit[d] = 0; m_o[d] = 0; m_sum[d] = 0; m_k[d] = 0;
                m_flag[d] = 0; m_ovf[d] = 0;
            end else if (!m_emit[d]) begin
                if (CLR) begin
                    m_sum[d] = 0; m_k[d] = 0; m_flag[d] = 0;
                end else if (I_VALID) begin
                    s = m_sum[d] + int'(I);
                    if (s >= lim) m_flag[d] = 1;
                    m_sum[d] = s % lim;
                    m_k[d]++;
                    if (m_k[d] == cnt_of(d)) begin
                        m_o[d]    = m_sum[d];
                        m_ovf[d]  = m_flag[d];
                        m_emit[d] = 1;
                        m_sum[d]  = 0; m_k[d] = 0; m_flag[d] = 0;
                    end
                end
            end else if (O_READY) begin
                m_emit[d] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(RESETN && !m_emit[d] && !CLR));
            chk($sformatf("vld%0d", d), 32'(vld[d]), 32'(m_emit[d]));
            chk($sformatf("o%0d", d), o_of(d), 32'(m_o[d]));
`ifdef TWO_OPS_ACC_OVF_EN
            chk($sformatf("ovf%0d", d), 32'(ovf[d]), 32'(m_ovf[d]));
`endif
        end
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] i, input bit c, input bit rd);
        drive(r, v, i, c, rd);
        tick();
    endtask

    initial begin
        bit rst_r, v_r, c_r, rd_r;
        logic [7:0] i_r;

        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        chk("rst_o", 32'(o0), 32'd0);
        chk("rst_vld", 32'(vld[0]), 32'd0);

        // basic block of four, O_READY high
        for (int k = 1; k <= 4; k++) step(1, 1, 8'(10 * k), 0, 1);
        chk("t1_vld", 32'(vld[0]), 32'd1);
        chk("t1_o", 32'(o0), 32'd100);
        step(1, 0, 0, 0, 1);
        chk("t1_hs_vld", 32'(vld[0]), 32'd0);
        drive(1, 1, 0, 0, 1);
        #1;
        chk("t1_rdy_after", 32'(rdy[0]), 32'd1);
        tick();

        // backpressure holds the result and the next word
        step(0, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) step(1, 1, 8'(10 * k), 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 8, 0, 0);
            chk("t2_hold_o", 32'(o0), 32'd100);
            chk("t2_hold_vld", 32'(vld[0]), 32'd1);
            chk("t2_hold_rdy", 32'(rdy[0]), 32'd0);
        end
        step(1, 1, 8, 0, 1);
        for (int k = 0; k < 4; k++) step(1, 1, 8, 0, 1);
        chk("t2_o32", 32'(o0), 32'd32);
        chk("t2_vld", 32'(vld[0]), 32'd1);
        step(1, 0, 0, 0, 1);

        // full-scale words: no wrap at 10 bits, wrap at 9 bits
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(1, 1, 8'hFF, 0, 1);
        chk("t3_o10", 32'(o0), 32'd1020);
        chk("t3_o9", 32'(o1), 32'd508);
`ifdef TWO_OPS_ACC_OVF_EN
        chk("t3_ovf10", 32'(ovf[0]), 32'd0);
        chk("t3_ovf9", 32'(ovf[1]), 32'd1);
`endif
        step(1, 0, 0, 0, 1);

        // CLR beats a simultaneous valid word
        step(0, 0, 0, 0, 1);
        step(1, 1, 5, 0, 1);
        step(1, 1, 7, 0, 1);
        step(1, 1, 9, 1, 1);
        for (int k = 1; k <= 4; k++) step(1, 1, 8'(k), 0, 1);
        chk("t4_o", 32'(o0), 32'd10);
        chk("t4_vld", 32'(vld[0]), 32'd1);
        step(1, 0, 0, 0, 1);

        // COUNT=1 passes each word straight through
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 8'hAB, 0, k[0]);
            if (vld[2]) chk("t5_o", 32'(o2), 32'h0AB);
        end
        step(1, 0, 0, 0, 1);

        // reset while an output is pending
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(1, 1, 1, 0, 0);
        chk("t6_pend", 32'(vld[0]), 32'd1);
        step(0, 1, 1, 0, 0);
        chk("t6_rst_vld", 32'(vld[0]), 32'd0);
        chk("t6_rst_o", 32'(o0), 32'd0);
        for (int k = 0; k < 4; k++) step(1, 1, 1, 0, 1);
        chk("t6_o4", 32'(o0), 32'd4);
        step(1, 0, 0, 0, 1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_r = ($urandom_range(63) != 0);
            v_r   = ($urandom_range(3) != 0);
            c_r   = ($urandom_range(7) == 0);
            rd_r  = $urandom_range(1) != 0;
            i_r   = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            step(rst_r, v_r, i_r, c_r, rd_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/two_ops_acc.md
Name: two_ops_acc

Overview:
- Downstream consumer of the 8-bit two-operand subtract stage.
- Takes that stage's result stream over a valid/ready handshake and sums COUNT consecutive results into a wider accumulator.
- Presents each completed sum on a held valid/ready output port.
- Turns the combinational two-op datapath into a block-reduction stage with backpressure.

Parameters:
- COUNT, 4: results summed per output word. Legal range 1..256.
- ACC_W, 10: accumulator and output width. Must be >= 8. Sum wraps modulo 2^ACC_W.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESETN  input  1  reset, synchronous, active-low.
- I  input  8  result word from the two-op stage, unsigned, zero-extended to ACC_W.
- I_VALID  input  1  I is valid this cycle.
- I_READY  output  1  block accepts I this cycle.
- CLR  input  1  synchronous discard of the partial sum.
- O  output  ACC_W  completed sum.
- O_VALID  output  1  O is valid.
- O_READY  input  1  downstream accepts O.

Behaviour:
- Reset (RESETN=0 at an edge):
  - state=ACCUM, acc=0, cnt=0, O=0, O_VALID=0.
  - I_READY is 0 in any cycle where RESETN=0.
  - Reset mid-block or mid-EMIT drops all pending data.
- State ACCUM:
  - I_READY = !CLR.
  - Accept occurs when I_VALID && I_READY.
  - On accept with cnt<COUNT-1: acc += I (mod 2^ACC_W), cnt++.
  - On accept with cnt==COUNT-1: O <= acc+I, O_VALID <= 1, acc <= 0, cnt <= 0, state <= EMIT.
  - O_VALID rises the cycle after the COUNT-th accept, so latency is 1 cycle from the last accepted word.
- State EMIT:
  - I_READY=0.
  - O and O_VALID are held stable until O_READY=1.
  - On O_VALID && O_READY: O_VALID <= 0, state <= ACCUM, so the next word is accepted the following cycle.
  - O keeps its last value after the handshake; its value is don't-care while O_VALID=0.
- CLR:
  - In ACCUM: acc <= 0, cnt <= 0. A word presented in the same cycle is not accepted (I_READY=0), so CLR wins over a simultaneous I_VALID.
  - In EMIT: ignored. The pending output always completes.
- COUNT=1: every accepted word goes directly to EMIT with O=zero_ext(I).
- Counter width is max(1, clog2(COUNT)). cnt never exceeds COUNT-1.
- The upstream stage holds I stable while I_VALID && !I_READY. This block places no combinational path from I_VALID to I_READY; I_READY depends only on state and CLR.

Optional Feature:
- Macro: TWO_OPS_ACC_OVF_EN.
- When defined:
  - Adds output OVF (1 bit).
  - An internal sticky flag sets on any accept whose addition carries out of ACC_W bits.
  - OVF is loaded with that flag alongside O on EMIT entry and is valid with O_VALID.
  - The flag clears on EMIT entry, on CLR, and on reset. OVF resets to 0.
- When undefined: no OVF port and no carry logic; wrap is silent.

Decomposition:
- Package two_ops_pkg holds:
  - DATA_W=8 constant shared with the two-op stage.
  - State enum {ACCUM, EMIT}.
  - Function computing the counter width from COUNT.
- No sub-module. The block is a single FSM plus accumulator and counter, about 150 lines.

Test Plan:
- Reset, then stream I=10,20,30,40 with I_VALID=1 and O_READY=1 (defaults) -> O_VALID high exactly 1 cycle after the 4th accept, O=100, then I_READY=1 the cycle after the handshake.
- Same stream with O_READY=0 for 5 cycles -> O=100 and O_VALID held stable, I_READY=0 throughout, no words lost; a following 4x8 block gives O=32.
- 4x255 with ACC_W=10 -> O=1020, no wrap. With ACC_W=9 -> O=508; under TWO_OPS_ACC_OVF_EN, OVF=1.
- Accept 5 and 7, assert CLR together with I_VALID on I=9, then send 1,2,3,4 -> 9 not accepted, O=10.
- COUNT=1, I=0xAB, O_READY toggling every cycle -> each word emitted as O=0x0AB, one output per accept, never two accepts without an intervening handshake.
- RESETN=0 while in EMIT with O_VALID=1 -> next cycle O_VALID=0 and O=0; after release, a fresh 4-word block 1,1,1,1 gives O=4.
